// File: rtl/quotient_shift_ctrl.sv
// ---------------------------------------------------------------------------
// quotient_shift_ctrl : quotient bit accumulator with IDLE/ACCUM/FULL control.
// Optional overflow flag o_ovf enabled by macro QUOT_SHIFT_OVF_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module quotient_shift_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_load,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_shift,
  input  logic                       i_qbit,
  output logic [WIDTH-1:0]           o_q,
  output logic [$clog2(WIDTH+1)-1:0] o_cnt,
  output logic                       o_busy,
  output logic                       o_done,
`ifdef QUOT_SHIFT_OVF_EN
  output logic                       o_ovf,
`endif
  output logic                       o_done_pls
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_pls_q, done_pls_d;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    w_cnt_inc;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {q_q[WIDTH-2:0], i_qbit};
    end else begin : g_lsb_first
      assign w_shifted = {i_qbit, q_q[WIDTH-1:1]};
    end
  endgenerate

  assign w_cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    if (i_clr) begin
      state_d = ST_IDLE;
      q_d     = '0;
      cnt_d   = '0;
    end else if (i_load) begin
      state_d = ST_ACCUM;
      q_d     = i_data;
      cnt_d   = '0;
    end else if (i_shift && (state_q == ST_ACCUM)) begin
      q_d   = w_shifted;
      cnt_d = w_cnt_inc;
      if (w_cnt_inc == CW'(WIDTH)) begin
        state_d = ST_FULL;
      end
    end
    // Status flags are registered copies of the next state, so they change
    // on the same edge that accepts the request.
    busy_d     = (state_d == ST_ACCUM);
    done_d     = (state_d == ST_FULL);
    done_pls_d = (state_d == ST_FULL) && (state_q != ST_FULL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      q_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_pls_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_pls_q <= done_pls_d;
    end
  end

`ifdef QUOT_SHIFT_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky until reset, clear or load; a shift dropped by priority never sets it.
  always_comb begin
    ovf_d = ovf_q;
    if (i_clr || i_load) begin
      ovf_d = 1'b0;
    end else if (i_shift && (state_q == ST_FULL)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_ovf = ovf_q;
`endif

  assign o_q        = q_q;
  assign o_cnt      = cnt_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_done_pls = done_pls_q;

endmodule

`default_nettype wire
